// File: rtl/m68k_wb_bridge_pkg.sv
// Shared types and helpers for the 68000-to-Wishbone bridge.
package m68kwb_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    STROBE_WAIT = 2'd1,
    BUS         = 2'd2,
    DONE        = 2'd3
  } state_t;

  localparam logic [3:0] SEL_NONE = 4'b0000;

  // Big-endian lane mapping: the even 16-bit half (h=0) sits on the upper Wishbone lanes.
  function automatic logic [3:0] sel_from_strobes(input logic h, input logic uds_n,
                                                  input logic lds_n);
    logic [1:0] pair;
    pair = {~uds_n, ~lds_n};
    return h ? {2'b00, pair} : {pair, 2'b00};
  endfunction

endpackage

// File: rtl/m68k_wb_bridge_if.sv
// 68000 bus and Wishbone classic bus signals seen by the bridge.
interface m68k_wb_bridge_if #(
  parameter int unsigned AW = 24
);
  logic [AW-1:1] M68K_ADR_I;
  logic [15:0]   M68K_DAT_I;
  logic [15:0]   M68K_DAT_O;
  logic          AS_N_I;
  logic          UDS_N_I;
  logic          LDS_N_I;
  logic          RW_I;
  logic          DTACK_N_O;
  logic          BERR_N_O;
  logic [AW-1:0] ADR_O;
  logic [31:0]   DAT_O;
  logic [31:0]   DAT_I;
  logic [3:0]    SEL_O;
  logic          CYC_O;
  logic          STB_O;
  logic          WE_O;
  logic          ACK_I;
  logic          ERR_I;

  modport master (
    input  M68K_ADR_I, M68K_DAT_I, AS_N_I, UDS_N_I, LDS_N_I, RW_I, DAT_I, ACK_I, ERR_I,
    output M68K_DAT_O, DTACK_N_O, BERR_N_O, ADR_O, DAT_O, SEL_O, CYC_O, STB_O, WE_O
  );

  modport slave (
    output M68K_ADR_I, M68K_DAT_I, AS_N_I, UDS_N_I, LDS_N_I, RW_I, DAT_I, ACK_I, ERR_I,
    input  M68K_DAT_O, DTACK_N_O, BERR_N_O, ADR_O, DAT_O, SEL_O, CYC_O, STB_O, WE_O
  );
endinterface

// File: rtl/m68k_wb_bridge.sv
// One 68000 bus cycle -> one Wishbone classic single cycle with byte selects.
// Optional bus watchdog enabled by defining M68K_WB_TIMEOUT_EN.
module m68k_wb_bridge
  import m68kwb_pkg::*;
#(
  parameter int unsigned AW      = 24,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  m68k_wb_bridge_if.master bus
);

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_t      state;
  logic        abort_q;
  logic        h_q;
  logic        strobe_c;
  logic        start_c;
  logic        abort_c;
  logic        done_c;
  logic        timeout_c;
  logic        read_ack_c;
  logic        hi_en_c;
  logic        lo_en_c;
  logic [15:0] half_c;
  logic [15:0] rdata_c;

  assign strobe_c   = ~bus.UDS_N_I | ~bus.LDS_N_I;
  assign start_c    = ((state == IDLE) || (state == STROBE_WAIT)) && !bus.AS_N_I && strobe_c;
  // Once AS has been seen high during BUS the CPU has walked away; finish silently.
  assign abort_c    = abort_q | bus.AS_N_I;
  assign done_c     = bus.ACK_I | bus.ERR_I | timeout_c;
  assign read_ack_c = (state == BUS) && bus.ACK_I && !bus.ERR_I && !abort_c && !bus.WE_O;

  // Pick the addressed half and zero any byte lane the CPU did not strobe.
  assign half_c  = h_q ? bus.DAT_I[15:0] : bus.DAT_I[31:16];
  assign hi_en_c = h_q ? bus.SEL_O[1] : bus.SEL_O[3];
  assign lo_en_c = h_q ? bus.SEL_O[0] : bus.SEL_O[2];
  assign rdata_c = {hi_en_c ? half_c[15:8] : 8'h00, lo_en_c ? half_c[7:0] : 8'h00};

`ifdef M68K_WB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;

  assign timeout_c = (state == BUS) && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I)              cnt_q <= '0;
    else if (start_c)        cnt_q <= '0;
    else if (state == BUS)   cnt_q <= cnt_q + CW'(1);
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Control FSM with registered bus outputs.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state         <= IDLE;
      abort_q       <= 1'b0;
      bus.CYC_O     <= 1'b0;
      bus.STB_O     <= 1'b0;
      bus.WE_O      <= 1'b0;
      bus.SEL_O     <= SEL_NONE;
      bus.DTACK_N_O <= 1'b1;
      bus.BERR_N_O  <= 1'b1;
    end else begin
      case (state)
        IDLE, STROBE_WAIT: begin
          if (start_c) begin
            state     <= BUS;
            abort_q   <= 1'b0;
            bus.CYC_O <= 1'b1;
            bus.STB_O <= 1'b1;
            bus.WE_O  <= ~bus.RW_I;
            bus.SEL_O <= sel_from_strobes(bus.M68K_ADR_I[1], bus.UDS_N_I, bus.LDS_N_I);
          end else if (bus.AS_N_I) begin
            state <= IDLE;
          end else begin
            state <= STROBE_WAIT;
          end
        end
        BUS: begin
          if (done_c) begin
            abort_q   <= 1'b0;
            bus.CYC_O <= 1'b0;
            bus.STB_O <= 1'b0;
            bus.WE_O  <= 1'b0;
            bus.SEL_O <= SEL_NONE;
            if (abort_c) begin
              state <= IDLE;
            end else begin
              state <= DONE;
              if (bus.ERR_I || !bus.ACK_I) bus.BERR_N_O  <= 1'b0;
              else                         bus.DTACK_N_O <= 1'b0;
            end
          end else begin
            abort_q <= abort_c;
          end
        end
        DONE: begin
          if (bus.AS_N_I) begin
            state         <= IDLE;
            bus.DTACK_N_O <= 1'b1;
            bus.BERR_N_O  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address/data capture on entry to BUS and read-data capture at ACK.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      h_q            <= 1'b0;
      bus.ADR_O      <= '0;
      bus.DAT_O      <= '0;
      bus.M68K_DAT_O <= '0;
    end else begin
      if (start_c) begin
        h_q       <= bus.M68K_ADR_I[1];
        bus.ADR_O <= {bus.M68K_ADR_I[AW-1:2], 2'b00};
        bus.DAT_O <= {bus.M68K_DAT_I, bus.M68K_DAT_I};
      end
      if (read_ack_c) bus.M68K_DAT_O <= rdata_c;
    end
  end

endmodule

// File: tb/tb_m68k_wb_bridge.sv
// Directed self-checking bench for m68k_wb_bridge (build with M68K_WB_TIMEOUT_EN for the watchdog case).
module tb_m68k_wb_bridge;

  logic        clk;
  logic        rst_n;
  logic        ack_en;
  logic        err_en;
  logic [31:0] slave_dat;
  int          checks;
  int          errors;

  m68k_wb_bridge_if #(.AW(24)) bus ();

  m68k_wb_bridge #(.AW(24), .TIMEOUT(15)) dut (
    .CLK_I (clk),
    .RST_I (rst_n),
    .bus   (bus)
  );

  // Combinational slave: answers in the same cycle as STB_O.
  assign bus.ACK_I = ack_en & bus.CYC_O & bus.STB_O;
  assign bus.ERR_I = err_en & bus.CYC_O & bus.STB_O;
  assign bus.DAT_I = slave_dat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cpu_idle();
    bus.AS_N_I  = 1'b1;
    bus.UDS_N_I = 1'b1;
    bus.LDS_N_I = 1'b1;
    bus.RW_I    = 1'b1;
  endtask

  task automatic cpu_start(input logic [23:0] a, input logic uds_n, input logic lds_n,
                           input logic rw, input logic [15:0] d);
    bus.M68K_ADR_I = a[23:1];
    bus.M68K_DAT_I = d;
    bus.RW_I       = rw;
    bus.UDS_N_I    = uds_n;
    bus.LDS_N_I    = lds_n;
    bus.AS_N_I     = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if ({bus.CYC_O, bus.STB_O, bus.WE_O} !== 3'b000) begin errors++;
      $display("FAIL reset_ctl got %b exp 000", {bus.CYC_O, bus.STB_O, bus.WE_O}); end
    checks++; if (bus.SEL_O !== 4'h0 || bus.ADR_O !== 24'h0 || bus.DAT_O !== 32'h0) begin errors++;
      $display("FAIL reset_bus sel %h adr %h dat %h exp zeros", bus.SEL_O, bus.ADR_O, bus.DAT_O); end
    checks++; if ({bus.DTACK_N_O, bus.BERR_N_O} !== 2'b11 || bus.M68K_DAT_O !== 16'h0) begin errors++;
      $display("FAIL reset_cpu dtack/berr %b dat %h exp 11/0000", {bus.DTACK_N_O, bus.BERR_N_O}, bus.M68K_DAT_O); end
  endtask

  task automatic test_word_read();
    ack_en = 1'b1; slave_dat = 32'h1234_5678;
    cpu_start(24'h000004, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick();
    checks++; if ({bus.CYC_O, bus.STB_O, bus.WE_O} !== 3'b110) begin errors++;
      $display("FAIL rd_ctl got %b exp 110", {bus.CYC_O, bus.STB_O, bus.WE_O}); end
    checks++; if (bus.SEL_O !== 4'b1100) begin errors++;
      $display("FAIL rd_sel got %b exp 1100", bus.SEL_O); end
    checks++; if (bus.ADR_O !== 24'h000004) begin errors++;
      $display("FAIL rd_adr got %h exp 000004", bus.ADR_O); end
    checks++; if (bus.DTACK_N_O !== 1'b1) begin errors++;
      $display("FAIL rd_dtack_early got %b exp 1", bus.DTACK_N_O); end
    tick();
    checks++; if (bus.DTACK_N_O !== 1'b0 || bus.CYC_O !== 1'b0) begin errors++;
      $display("FAIL rd_dtack got dtack %b cyc %b exp 0 0", bus.DTACK_N_O, bus.CYC_O); end
    checks++; if (bus.M68K_DAT_O !== 16'h1234) begin errors++;
      $display("FAIL rd_data got %h exp 1234", bus.M68K_DAT_O); end
    cpu_idle(); tick();
    checks++; if (bus.DTACK_N_O !== 1'b1) begin errors++;
      $display("FAIL rd_release got %b exp 1", bus.DTACK_N_O); end
  endtask

  task automatic test_byte_read();
    ack_en = 1'b1; slave_dat = 32'hAABB_CCDD;
    cpu_start(24'h000010, 1'b0, 1'b1, 1'b1, 16'h0000);
    tick();
    checks++; if (bus.SEL_O !== 4'b1000 || bus.ADR_O !== 24'h000010) begin errors++;
      $display("FAIL brd_hi_sel got %b adr %h exp 1000 000010", bus.SEL_O, bus.ADR_O); end
    tick();
    checks++; if (bus.M68K_DAT_O !== 16'hAA00) begin errors++;
      $display("FAIL brd_hi_data got %h exp aa00", bus.M68K_DAT_O); end
    cpu_idle(); tick();
    cpu_start(24'h000012, 1'b1, 1'b0, 1'b1, 16'h0000);
    tick();
    checks++; if (bus.SEL_O !== 4'b0001) begin errors++;
      $display("FAIL brd_lo_sel got %b exp 0001", bus.SEL_O); end
    tick();
    checks++; if (bus.M68K_DAT_O !== 16'h00DD) begin errors++;
      $display("FAIL brd_lo_data got %h exp 00dd", bus.M68K_DAT_O); end
    cpu_idle(); tick();
  endtask

  task automatic test_byte_write();
    ack_en = 1'b1;
    cpu_start(24'h000007, 1'b1, 1'b1, 1'b0, 16'h00A5);
    tick();
    checks++; if (bus.CYC_O !== 1'b0) begin errors++;
      $display("FAIL wr_strobe_wait cyc %b exp 0", bus.CYC_O); end
    bus.LDS_N_I = 1'b0;
    tick();
    checks++; if (bus.SEL_O !== 4'b0001 || bus.WE_O !== 1'b1 || bus.CYC_O !== 1'b1) begin errors++;
      $display("FAIL wr_ctl sel %b we %b cyc %b exp 0001 1 1", bus.SEL_O, bus.WE_O, bus.CYC_O); end
    checks++; if (bus.DAT_O !== 32'h00A5_00A5 || bus.ADR_O !== 24'h000004) begin errors++;
      $display("FAIL wr_data dat %h adr %h exp 00a500a5 000004", bus.DAT_O, bus.ADR_O); end
    tick();
    checks++; if (bus.DTACK_N_O !== 1'b0) begin errors++;
      $display("FAIL wr_dtack got %b exp 0", bus.DTACK_N_O); end
    tick();
    checks++; if (bus.DTACK_N_O !== 1'b0 || bus.CYC_O !== 1'b0) begin errors++;
      $display("FAIL wr_hold dtack %b cyc %b exp 0 0", bus.DTACK_N_O, bus.CYC_O); end
    cpu_idle(); tick();
    checks++; if (bus.DTACK_N_O !== 1'b1) begin errors++;
      $display("FAIL wr_release got %b exp 1", bus.DTACK_N_O); end
  endtask

  task automatic test_err_ack();
    ack_en = 1'b1; err_en = 1'b1; slave_dat = 32'h5555_AAAA;
    cpu_start(24'h000020, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick();
    checks++; if (bus.CYC_O !== 1'b1) begin errors++;
      $display("FAIL err_cyc_on got %b exp 1", bus.CYC_O); end
    tick();
    checks++; if ({bus.BERR_N_O, bus.DTACK_N_O, bus.CYC_O} !== 3'b010) begin errors++;
      $display("FAIL err_resp berr/dtack/cyc %b exp 010", {bus.BERR_N_O, bus.DTACK_N_O, bus.CYC_O}); end
    err_en = 1'b0; cpu_idle(); tick();
    checks++; if (bus.BERR_N_O !== 1'b1) begin errors++;
      $display("FAIL err_release got %b exp 1", bus.BERR_N_O); end
  endtask

  task automatic test_abort();
    ack_en = 1'b0;
    cpu_start(24'h000030, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick();
    cpu_idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.STB_O !== 1'b1 || bus.DTACK_N_O !== 1'b1) begin errors++;
        $display("FAIL abort_hold%0d stb %b dtack %b exp 1 1", i, bus.STB_O, bus.DTACK_N_O); end
    end
    ack_en = 1'b1; tick();
    checks++; if ({bus.CYC_O, bus.DTACK_N_O, bus.BERR_N_O} !== 3'b011) begin errors++;
      $display("FAIL abort_end cyc/dtack/berr %b exp 011", {bus.CYC_O, bus.DTACK_N_O, bus.BERR_N_O}); end
    slave_dat = 32'h0BAD_BEEF;
    cpu_start(24'h000032, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick();
    checks++; if (bus.CYC_O !== 1'b1 || bus.DTACK_N_O !== 1'b1) begin errors++;
      $display("FAIL abort_next cyc %b dtack %b exp 1 1", bus.CYC_O, bus.DTACK_N_O); end
    tick();
    checks++; if (bus.DTACK_N_O !== 1'b0 || bus.M68K_DAT_O !== 16'hBEEF) begin errors++;
      $display("FAIL abort_next_ack dtack %b dat %h exp 0 beef", bus.DTACK_N_O, bus.M68K_DAT_O); end
    cpu_idle(); tick();
  endtask

  task automatic test_back_to_back();
    ack_en = 1'b1; slave_dat = 32'h8765_4321;
    cpu_start(24'h000040, 1'b0, 1'b0, 1'b0, 16'hBEEF);
    tick(); tick();
    tick();
    checks++; if (bus.CYC_O !== 1'b0 || bus.DTACK_N_O !== 1'b0) begin errors++;
      $display("FAIL b2b_no_restart cyc %b dtack %b exp 0 0", bus.CYC_O, bus.DTACK_N_O); end
    cpu_idle(); tick();
    cpu_start(24'h000042, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick();
    checks++; if (bus.CYC_O !== 1'b1 || bus.SEL_O !== 4'b0011) begin errors++;
      $display("FAIL b2b_second cyc %b sel %b exp 1 0011", bus.CYC_O, bus.SEL_O); end
    tick();
    checks++; if (bus.DTACK_N_O !== 1'b0 || bus.M68K_DAT_O !== 16'h4321) begin errors++;
      $display("FAIL b2b_data dtack %b dat %h exp 0 4321", bus.DTACK_N_O, bus.M68K_DAT_O); end
    cpu_idle(); tick();
  endtask

  task automatic test_reset_mid_bus();
    ack_en = 1'b0;
    cpu_start(24'h000008, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick();
    checks++; if (bus.CYC_O !== 1'b1) begin errors++;
      $display("FAIL rst_pre cyc %b exp 1", bus.CYC_O); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.CYC_O, bus.STB_O} !== 2'b00 || bus.SEL_O !== 4'h0) begin errors++;
      $display("FAIL rst_async cyc/stb %b sel %b exp 00 0000", {bus.CYC_O, bus.STB_O}, bus.SEL_O); end
    checks++; if ({bus.DTACK_N_O, bus.BERR_N_O} !== 2'b11) begin errors++;
      $display("FAIL rst_resp dtack/berr %b exp 11", {bus.DTACK_N_O, bus.BERR_N_O}); end
    cpu_idle();
    @(negedge clk); rst_n = 1'b1;
    tick();
    ack_en = 1'b1; slave_dat = 32'hCAFE_F00D;
    cpu_start(24'h00000A, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick();
    checks++; if (bus.SEL_O !== 4'b0011 || bus.ADR_O !== 24'h000008) begin errors++;
      $display("FAIL rst_after_sel sel %b adr %h exp 0011 000008", bus.SEL_O, bus.ADR_O); end
    tick();
    checks++; if (bus.DTACK_N_O !== 1'b0 || bus.M68K_DAT_O !== 16'hF00D) begin errors++;
      $display("FAIL rst_after_data dtack %b dat %h exp 0 f00d", bus.DTACK_N_O, bus.M68K_DAT_O); end
    cpu_idle(); tick();
  endtask

  task automatic test_no_ack();
    int cyc_high;
    ack_en = 1'b0; err_en = 1'b0;
    cpu_start(24'h000050, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick();
`ifdef M68K_WB_TIMEOUT_EN
    cyc_high = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      checks++; if (bus.BERR_N_O !== ((k == 15) ? 1'b0 : 1'b1) || bus.CYC_O !== ((k == 15) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL tmo_cycle%0d berr %b cyc %b", k, bus.BERR_N_O, bus.CYC_O); end
    end
    cpu_idle(); tick();
    checks++; if (bus.BERR_N_O !== 1'b1) begin errors++;
      $display("FAIL tmo_release got %b exp 1", bus.BERR_N_O); end
`else
    cyc_high = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (bus.CYC_O === 1'b1 && bus.BERR_N_O === 1'b1) cyc_high++;
    end
    checks++; if (cyc_high !== 100) begin errors++;
      $display("FAIL wait_forever cyc high %0d cycles exp 100", cyc_high); end
    cpu_idle(); tick();
    ack_en = 1'b1; tick();
    checks++; if (bus.CYC_O !== 1'b0 || bus.DTACK_N_O !== 1'b1) begin errors++;
      $display("FAIL wait_abort cyc %b dtack %b exp 0 1", bus.CYC_O, bus.DTACK_N_O); end
`endif
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; ack_en = 1'b0; err_en = 1'b0; slave_dat = 32'h0;
    bus.M68K_ADR_I = '0; bus.M68K_DAT_I = '0;
    cpu_idle();
    tick(); tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_word_read();
    test_byte_read();
    test_byte_write();
    test_err_ack();
    test_abort();
    test_back_to_back();
    test_reset_mid_bus();
    test_no_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m68k_wb_bridge.md
Name: m68k_wb_bridge

Overview:
- Upstream master for the 32-bit Wishbone memory slave. Converts one 68000-style 16-bit bus cycle (AS/UDS/LDS/RW, DTACK/BERR) into one Wishbone classic single cycle with byte selects.
- 68k-side signals are synchronous to CLK_I; the CPU model shares the clock domain.
- Provides the data-path half-select, big-endian lane mapping and the bus-error return path.

Parameters:
- AW, 24: Wishbone address width. The 68k address input is AW-1 bits wide, bits [AW-1:1].
- TIMEOUT, 15: watchdog limit in CLK_I cycles. Used only with the optional feature.

Ports:
- CLK_I  in  1  system clock, rising edge
- RST_I  in  1  reset; asynchronous, active-low
- M68K_ADR_I  in  AW-1  CPU address bits [AW-1:1]
- M68K_DAT_I  in  16  CPU write data
- M68K_DAT_O  out  16  read data to CPU, valid while DTACK_N_O low
- AS_N_I  in  1  address strobe, active-low
- UDS_N_I  in  1  upper data strobe (D15:8), active-low
- LDS_N_I  in  1  lower data strobe (D7:0), active-low
- RW_I  in  1  1=read, 0=write
- DTACK_N_O  out  1  data acknowledge, active-low
- BERR_N_O  out  1  bus error, active-low
- ADR_O  out  AW  Wishbone byte address; bits [1:0] always 0
- DAT_O  out  32  Wishbone write data
- DAT_I  in  32  Wishbone read data
- SEL_O  out  4  byte selects
- CYC_O  out  1  Wishbone cycle
- STB_O  out  1  Wishbone strobe
- WE_O  out  1  Wishbone write enable
- ACK_I  in  1  slave acknowledge; may be combinational in the same cycle as STB_O
- ERR_I  in  1  slave error

Behaviour:
- Reset (RST_I low, asynchronous) values:
  - CYC_O=STB_O=WE_O=0, SEL_O=0, ADR_O=0, DAT_O=0
  - DTACK_N_O=BERR_N_O=1, M68K_DAT_O=0
  - FSM=IDLE
  - Reset in any state aborts immediately; no DTACK is issued.
- All Wishbone and 68k outputs are registered.
- Lane mapping (big-endian), h = M68K_ADR_I[1]:
  - h=0: UDS->SEL[3], LDS->SEL[2]
  - h=1: UDS->SEL[1], LDS->SEL[0]
  - SEL bits for the unused half are 0.
- ADR_O = {M68K_ADR_I[AW-1:2], 2'b00}, latched on entry to BUS.
- DAT_O = {M68K_DAT_I, M68K_DAT_I}, replicated on both halves and latched on entry to BUS.
- Read data: latched at ACK. h=0 selects DAT_I[31:16]; h=1 selects DAT_I[15:0]. Lanes not selected return 0.
- FSM:
  - IDLE: AS low and (UDS low or LDS low) -> BUS. AS low with both strobes high -> STROBE_WAIT.
  - STROBE_WAIT (write data strobes lag AS): any strobe low -> BUS. AS high -> IDLE.
  - BUS: CYC_O=STB_O=1, WE_O=~RW_I.
    - At the clock edge with ERR_I=1 -> DONE with BERR_N_O=0. ERR wins if ACK_I and ERR_I are both high.
    - Else at the edge with ACK_I=1 -> DONE with DTACK_N_O=0 and read data latched.
    - Leaving BUS drops CYC/STB/SEL the same edge.
  - DONE: hold DTACK_N_O/BERR_N_O low until AS_N_I samples high, then release both -> IDLE.
- Latency, with a combinational-ACK slave:
  - AS+strobe sampled at edge n; CYC/STB high after n.
  - DTACK_N_O low after n+1.
  - 2 cycles from AS to DTACK.
- Abort: AS rising while in BUS completes the Wishbone cycle (no STB drop before ACK/ERR), then goes directly to IDLE with no DTACK/BERR pulse.
- Back-to-back: a new AS is accepted only after AS has been observed high in DONE or IDLE.
- Only one outstanding Wishbone cycle; no pipelining.

Optional Feature:
- Macro: M68K_WB_TIMEOUT_EN
- Defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to BUS and increments each cycle in BUS.
  - On reaching TIMEOUT without ACK/ERR: drop CYC/STB, go to DONE with BERR_N_O=0.
  - ACK_I or ERR_I in the same cycle as the timeout takes priority.
- Undefined: no counter; BUS waits indefinitely.

Decomposition:
- Shared package m68kwb_pkg holds:
  - state enum (IDLE, STROBE_WAIT, BUS, DONE), 2 bits
  - lane-mapping function sel_from_strobes(h, uds_n, lds_n)
  - constant SEL_NONE=4'b0000
- No sub-module. The FSM and data path are a single module; the timeout counter is inline under the macro.

Test Plan:
- Word read at 0x000004: AS/UDS/LDS low, RW=1, slave ACK combinational -> SEL_O=4'b1100, ADR_O=0x000004, DTACK_N_O low 2 cycles after AS, M68K_DAT_O=DAT_I[31:16].
- Byte write at 0x000007 (h=1, LDS only): AS low one cycle before LDS, data 0x00A5 -> STROBE_WAIT for 1 cycle, then SEL_O=4'b0001, WE_O=1, DAT_O=0x00A500A5, DTACK_N_O low until AS high.
- Slave asserts ERR_I and ACK_I together -> BERR_N_O=0, DTACK_N_O stays 1, CYC_O drops the next edge.
- AS released while the slave withholds ACK for 3 cycles -> STB_O held until ACK, then IDLE, no DTACK/BERR pulse.
- RST_I low mid-BUS -> CYC_O/STB_O/SEL_O=0 immediately (asynchronous), FSM=IDLE, next AS accepted normally after release.
- With M68K_WB_TIMEOUT_EN, TIMEOUT=15, slave never acks -> BERR_N_O low after 15 BUS cycles, CYC_O=0; without the macro, CYC_O stays high for 100 cycles.
